histogram_peak_finder: RTL

Downstream consumer of the histogram stage: on a `start` pulse it requests the x/y projection histograms of the median-filtered image, walks both bin streams, and reports per axis the peak bin, the peak count, and the first/last bins whose count reaches `minCount`. The result is a bounding box plus the peak location of the object in the filtered image. It is handed to the control logic with a one-cycle `resultValid` strobe.

---
 rtl/histogram_peak_finder_pkg.sv | 25 ++
 rtl/histogram_peak_finder_if.sv | 38 +++
 rtl/histogram_peak_finder_axis_scan.sv | 88 ++++++++
 rtl/histogram_peak_finder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/histogram_peak_finder_pkg.sv
// Shared definitions for the histogram peak finder: state encoding,
// bin/count widths and the occupancy test used by both axis scanners.
package histogram_peak_finder_pkg;

  localparam int BIN_W = 8;
  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQ     = ST_REQ,
    COLLECT = ST_COLLECT,
    DONE    = ST_DONE
  } state_t;

  function automatic logic qualifies(input logic [CNT_W-1:0] count,
                                     input logic [CNT_W-1:0] threshold);
    return count >= threshold;
  endfunction

endpackage

// File: rtl/histogram_peak_finder_if.sv
// Request, bin-stream and result signals between the histogram stage,
// the control logic and the peak finder.
interface histogram_peak_finder_if;
  import histogram_peak_finder_pkg::*;

  logic             start;
  logic [CNT_W-1:0] minCount;
  logic             readHistogram;
  logic [CNT_W-1:0] xHistogramIn;
  logic [CNT_W-1:0] yHistogramIn;
  logic             xValid;
  logic             yValid;
  logic             busy;
  logic             resultValid;
  logic [BIN_W-1:0] xPeak;
  logic [BIN_W-1:0] yPeak;
  logic [CNT_W-1:0] xPeakCount;
  logic [CNT_W-1:0] yPeakCount;
  logic [BIN_W-1:0] xMin;
  logic [BIN_W-1:0] xMax;
  logic [BIN_W-1:0] yMin;
  logic [BIN_W-1:0] yMax;
  logic             found;
  logic             timeoutErr;

  modport master (
    output start, minCount, xHistogramIn, yHistogramIn, xValid, yValid,
    input  readHistogram, busy, resultValid, xPeak, yPeak, xPeakCount,
           yPeakCount, xMin, xMax, yMin, yMax, found, timeoutErr
  );

  modport slave (
    input  start, minCount, xHistogramIn, yHistogramIn, xValid, yValid,
    output readHistogram, busy, resultValid, xPeak, yPeak, xPeakCount,
           yPeakCount, xMin, xMax, yMin, yMax, found, timeoutErr
  );

endinterface

// File: rtl/histogram_peak_finder_axis_scan.sv
// One projection axis: counts incoming bins and tracks peak and the first/last
// bin reaching the threshold. Next-state values are exported so the top can
// capture results on the same edge as the final beat.
module histogram_peak_finder_axis_scan
  import histogram_peak_finder_pkg::*;
#(
  parameter int NUM_BINS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic [CNT_W-1:0] data,
  input  logic [CNT_W-1:0] threshold,
  output logic             done,
  output logic             lastBeat,
  output logic [BIN_W-1:0] nextPeak,
  output logic [CNT_W-1:0] nextPeakCount,
  output logic [BIN_W-1:0] nextMin,
  output logic [BIN_W-1:0] nextMax,
  output logic             nextHit
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  logic [BIN_W-1:0] binIdx;
  logic [BIN_W-1:0] peak;
  logic [CNT_W-1:0] peakCount;
  logic [BIN_W-1:0] minBin;
  logic [BIN_W-1:0] maxBin;
  logic             hit;
  logic             accept;

  // Beats after the last bin are dropped so a chatty source cannot disturb results.
  assign accept   = valid && !done;
  assign lastBeat = accept && (binIdx == LAST_BIN);

  always_comb begin
    nextPeak      = peak;
    nextPeakCount = peakCount;
    nextMin       = minBin;
    nextMax       = maxBin;
    nextHit       = hit;
    if (accept) begin
      // Strict compare keeps the first occurrence on ties.
      if (data > peakCount) begin
        nextPeak      = binIdx;
        nextPeakCount = data;
      end
      if (qualifies(data, threshold)) begin
        if (!hit) nextMin = binIdx;
        nextMax = binIdx;
        nextHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      binIdx    <= '0;
      done      <= 1'b0;
      peak      <= '0;
      peakCount <= '0;
      minBin    <= '0;
      maxBin    <= '0;
      hit       <= 1'b0;
    end else if (clear) begin
      binIdx    <= '0;
      done      <= 1'b0;
      peak      <= '0;
      peakCount <= '0;
      minBin    <= '0;
      maxBin    <= '0;
      hit       <= 1'b0;
    end else begin
      if (accept) begin
        binIdx <= binIdx + 1'b1;
        if (binIdx == LAST_BIN) done <= 1'b1;
      end
      peak      <= nextPeak;
      peakCount <= nextPeakCount;
      minBin    <= nextMin;
      maxBin    <= nextMax;
      hit       <= nextHit;
    end
  end

endmodule

// File: rtl/histogram_peak_finder.sv
// Requests the x/y projection histograms, scans both bin streams and reports
// peak location plus bounding box with a one-cycle resultValid strobe.
module histogram_peak_finder
  import histogram_peak_finder_pkg::*;
#(
  parameter int NUM_BINS = 256,
  parameter int TIMEOUT  = 1023
) (
  input logic                    clk,
  input logic                    reset,
  histogram_peak_finder_if.slave bus
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state;
  state_t           nextState;
  logic [CNT_W-1:0] minCountQ;
  logic [TMO_W-1:0] idleCnt;
  logic             collecting;
  logic             clear;
  logic             anyValid;
  logic             finishing;
  logic             timeoutHit;
  logic             load;

  logic             xDone, yDone, xLast, yLast, xHit, yHit;
  logic [BIN_W-1:0] xPeakN, yPeakN, xMinN, yMinN, xMaxN, yMaxN;
  logic [CNT_W-1:0] xPeakCountN, yPeakCountN;

  assign collecting = (state == COLLECT);
  assign clear      = (state == IDLE) && bus.start;
  assign anyValid   = bus.xValid || bus.yValid;

  // Completion is detected on the edge that takes the final beat, so the
  // output registers capture the scanners' next-state values directly.
  assign finishing  = collecting && (xDone || xLast) && (yDone || yLast);
  assign timeoutHit = collecting && !finishing && !anyValid && (idleCnt == TMO_LAST);
  assign load       = finishing || timeoutHit;

  histogram_peak_finder_axis_scan #(.NUM_BINS(NUM_BINS)) xScan (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .valid         (collecting && bus.xValid),
    .data          (bus.xHistogramIn),
    .threshold     (minCountQ),
    .done          (xDone),
    .lastBeat      (xLast),
    .nextPeak      (xPeakN),
    .nextPeakCount (xPeakCountN),
    .nextMin       (xMinN),
    .nextMax       (xMaxN),
    .nextHit       (xHit)
  );

  histogram_peak_finder_axis_scan #(.NUM_BINS(NUM_BINS)) yScan (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .valid         (collecting && bus.yValid),
    .data          (bus.yHistogramIn),
    .threshold     (minCountQ),
    .done          (yDone),
    .lastBeat      (yLast),
    .nextPeak      (yPeakN),
    .nextPeakCount (yPeakCountN),
    .nextMin       (yMinN),
    .nextMax       (yMaxN),
    .nextHit       (yHit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start) nextState = REQ;
      REQ:     nextState = COLLECT;
      COLLECT: if (load) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign bus.readHistogram = (state == REQ);
  assign bus.busy          = (state != IDLE);
  assign bus.resultValid   = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      minCountQ <= '0;
      idleCnt   <= '0;
    end else if (clear) begin
      minCountQ <= bus.minCount;
      idleCnt   <= '0;
    end else if (collecting) begin
      idleCnt <= anyValid ? '0 : idleCnt + 1'b1;
    end
  end

  // ---- result capture: registers hold until the next completed or aborted run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.xPeak      <= '0;
      bus.yPeak      <= '0;
      bus.xPeakCount <= '0;
      bus.yPeakCount <= '0;
      bus.xMin       <= '0;
      bus.xMax       <= '0;
      bus.yMin       <= '0;
      bus.yMax       <= '0;
      bus.found      <= 1'b0;
      bus.timeoutErr <= 1'b0;
    end else if (load) begin
      bus.xPeak      <= xPeakN;
      bus.yPeak      <= yPeakN;
      bus.xPeakCount <= xPeakCountN;
      bus.yPeakCount <= yPeakCountN;
      bus.xMin       <= xMinN;
      bus.xMax       <= xMaxN;
      bus.yMin       <= yMinN;
      bus.yMax       <= yMaxN;
      bus.found      <= finishing && xHit && yHit;
      bus.timeoutErr <= !finishing;
    end
  end

endmodule
